load_store_unit: RTL

Memory-stage load/store unit. It replaces the single-cycle data memory path with a handshaked bus master. It takes the M-stage address, store data and funct3, and drives a word-wide request/acknowledge data bus. It returns aligned, sign- or zero-extended load data to the write-back register, and stalls the pipeline while an access is in flight.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 39 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 encodings, FSM state type and alignment helper for the load/store unit
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

   // halfwords need an even address, words a 4-byte aligned one
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
      return (funct3[1:0] == F3_H[1:0] && off[0]) || (funct3[1:0] == F3_W[1:0] && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores and lane extraction/extension for loads
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      i_st_size,
   input  logic [1:0]      i_st_off,
   input  logic [XLEN-1:0] i_st_wdata,
   output logic [3:0]      o_be,
   output logic [XLEN-1:0] o_wdata,
   input  logic [2:0]      i_ld_funct3,
   input  logic [1:0]      i_ld_off,
   input  logic [XLEN-1:0] i_ld_rdata,
   output logic [XLEN-1:0] o_ld_data
);

   logic [XLEN-1:0] w_shift;
   logic [15:0]     w_half;

   // byte enables and replicated write data derived from access size and offset
   always_comb begin
      o_be    = i_st_size == F3_B[1:0] ? 4'b0001 << i_st_off :
                i_st_size == F3_H[1:0] ? (i_st_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      o_wdata = i_st_size == F3_B[1:0] ? {4{i_st_wdata[7:0]}} :
                i_st_size == F3_H[1:0] ? {2{i_st_wdata[15:0]}} : i_st_wdata;
   end

   // pick the addressed lane and sign- or zero-extend it
   always_comb begin
      w_shift   = i_ld_rdata >> {i_ld_off, 3'b000};
      w_half    = i_ld_off[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
      o_ld_data = i_ld_funct3 == F3_B  ? {{(XLEN-8){w_shift[7]}}, w_shift[7:0]} :
                  i_ld_funct3 == F3_BU ? {{(XLEN-8){1'b0}}, w_shift[7:0]} :
                  i_ld_funct3 == F3_H  ? {{(XLEN-16){w_half[15]}}, w_half} :
                  i_ld_funct3 == F3_HU ? {{(XLEN-16){1'b0}}, w_half} : i_ld_rdata;
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: M-stage load/store unit driving a req/ack word bus and stalling the pipeline
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid_i,
   input  logic            req_we_i,
   input  logic [2:0]      req_funct3_i,
   input  logic [XLEN-1:0] req_addr_i,
   input  logic [XLEN-1:0] req_wdata_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misalign_o,
   output logic            fault_o,
   output logic            bus_req_o,
   output logic            bus_we_o,
   output logic [XLEN-1:0] bus_addr_o,
   output logic [3:0]      bus_be_o,
   output logic [XLEN-1:0] bus_wdata_o,
   input  logic            bus_ack_i,
   input  logic            bus_err_i,
   input  logic [XLEN-1:0] bus_rdata_i
);

   lsu_state_t      r_state, w_next;
   logic [15:0]     r_cnt;
   logic [2:0]      r_funct3;
   logic [1:0]      r_off;
   logic            r_we;
   logic            r_bus_req, r_bus_we;
   logic [XLEN-1:0] r_bus_addr, r_bus_wdata, r_rdata;
   logic [3:0]      r_bus_be;
   logic            r_fault;
   logic            w_illegal, w_misalign, w_timeout, w_stall, w_mis;
   logic [3:0]      w_be;
   logic [XLEN-1:0] w_wdata, w_ld_data;

   assign w_illegal  = req_we_i ? req_funct3_i > F3_W : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
   assign w_misalign = !w_illegal && is_misaligned(req_funct3_i, req_addr_i[1:0]);
   assign w_timeout  = r_cnt == 16'(TIMEOUT - 1);

   lsu_align #(.XLEN(XLEN)) u_align (
      .i_st_size   (req_funct3_i[1:0]),
      .i_st_off    (req_addr_i[1:0]),
      .i_st_wdata  (req_wdata_i),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .i_ld_funct3 (r_funct3),
      .i_ld_off    (r_off),
      .i_ld_rdata  (bus_rdata_i),
      .o_ld_data   (w_ld_data)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // next state plus combinational stall/misalign decode
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      w_mis   = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid_i && w_illegal) begin
               w_next  = DONE;
               w_stall = 1'b1;
            end else if (req_valid_i && w_misalign) begin
               w_mis = 1'b1;
            end else if (req_valid_i) begin
               w_next  = BUSY;
               w_stall = 1'b1;
            end
         end
         BUSY: begin
            w_stall = 1'b1;
            if (bus_ack_i || bus_err_i || w_timeout) w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
   end

   // latched request, bus drive, timeout counter and completion result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt       <= '0;
         r_funct3    <= '0;
         r_off       <= '0;
         r_we        <= 1'b0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_be    <= '0;
         r_bus_wdata <= '0;
         r_rdata     <= '0;
         r_fault     <= 1'b0;
      end else if (r_state == IDLE && w_next == BUSY) begin
         r_cnt       <= '0;
         r_funct3    <= req_funct3_i;
         r_off       <= req_addr_i[1:0];
         r_we        <= req_we_i;
         r_bus_req   <= 1'b1;
         r_bus_we    <= req_we_i;
         r_bus_addr  <= {req_addr_i[XLEN-1:2], 2'b00};
         r_bus_be    <= w_be;
         r_bus_wdata <= req_we_i ? w_wdata : '0;
      end else if (r_state == IDLE && w_next == DONE) begin
         r_fault <= 1'b1;
         r_rdata <= '0;
      end else if (r_state == BUSY && w_next == DONE) begin
         r_bus_req <= 1'b0;
         r_fault   <= bus_err_i || !bus_ack_i;
         r_rdata   <= (bus_ack_i && !bus_err_i && !r_we) ? w_ld_data : '0;
      end else if (r_state == BUSY) begin
         r_cnt <= r_cnt + 16'd1;
      end else if (r_state == DONE) begin
         r_fault <= 1'b0;
         r_rdata <= '0;
      end
   end

   assign stall_o     = rst && w_stall;
   assign misalign_o  = rst && w_mis;
   assign done_o      = r_state == DONE;
   assign rdata_o     = done_o ? r_rdata : '0;
   assign fault_o     = done_o && r_fault;
   assign bus_req_o   = r_bus_req;
   assign bus_we_o    = r_bus_we;
   assign bus_addr_o  = r_bus_addr;
   assign bus_be_o    = r_bus_be;
   assign bus_wdata_o = r_bus_wdata;

endmodule
